// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin arbiter with bounded lock for RAM port A
//
// Shares the single read/write port A of a synchronous dual-port RAM between
// two masters. Grants are combinational in the request cycle. Read data comes
// back from the RAM one cycle later and is flagged to the master that was granted.
//
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   req0/1, we0/1, lock0/1     per-master request, write enable, keep-port request
//   addr0/1, wdata0/1          per-master address and write data
//   gnt0/1                     combinational grant
//   rvalid0/1, rdata0/1        read response, one cycle after a granted read
//   ram_addr_A, ram_data_in_A, ram_w_e_A, ram_data_out_A   RAM port A pins

`timescale 1ns/1ps

module ram_port_arbiter #(
    parameter int ADDR_SIZE = 6,
    parameter int DATA_SIZE = 32,
    parameter int MAX_LOCK  = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic                 lock0,
    input  logic                 lock1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [DATA_SIZE-1:0] wdata0,
    input  logic [DATA_SIZE-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [DATA_SIZE-1:0] rdata0,
    output logic [DATA_SIZE-1:0] rdata1,
    output logic [ADDR_SIZE-1:0] ram_addr_A,
    output logic [DATA_SIZE-1:0] ram_data_in_A,
    output logic                 ram_w_e_A,
    input  logic [DATA_SIZE-1:0] ram_data_out_A
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    logic       last;
    logic       owner;
    logic       locked;
    logic [7:0] lock_cnt;
    logic       rd_pend0;
    logic       rd_pend1;

    logic any_req;
    logic req_own;
    logic req_oth;
    logic hold;
    logic force_sw;
    logic locked_grant;
    logic winner;
    logic win_lock;
    logic win_oth_req;

    always_comb begin
        req_own  = owner ? req1 : req0;
        req_oth  = owner ? req0 : req1;
        // Requests are ignored while reset is asserted.
        any_req  = nrst & (req0 | req1);
        hold     = locked & req_own;
        // Owner has used up its locked grants while the other side waited.
        force_sw = hold & req_oth & (lock_cnt == MAX_CNT);
        locked_grant = hold & ~force_sw;

        if (locked_grant) begin
            winner = owner;
        end else if (force_sw) begin
            winner = ~owner;
        end else if (req0 & req1) begin
            winner = ~last;
        end else begin
            winner = req1;
        end

        win_lock    = winner ? lock1 : lock0;
        win_oth_req = winner ? req0 : req1;

        gnt0 = any_req & ~winner;
        gnt1 = any_req & winner;
    end

    // With no grant the mux rests on requester 0 and write enable stays low.
    assign ram_addr_A    = (any_req & winner) ? addr1  : addr0;
    assign ram_data_in_A = (any_req & winner) ? wdata1 : wdata0;
    assign ram_w_e_A     = any_req & (winner ? we1 : we0);

    assign rvalid0 = rd_pend0;
    assign rvalid1 = rd_pend1;
    assign rdata0  = ram_data_out_A;
    assign rdata1  = ram_data_out_A;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last     <= 1'b1;
            owner    <= 1'b0;
            locked   <= 1'b0;
            lock_cnt <= 8'd0;
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            rd_pend0 <= gnt0 & ~we0;
            rd_pend1 <= gnt1 & ~we1;
            if (any_req) begin
                last <= winner;
                if (win_lock) begin
                    locked <= 1'b1;
                    owner  <= winner;
                    // Only grants taken under an existing lock count toward the
                    // limit; acquiring the lock (normally or after a forced
                    // switch) starts the count from zero.
                    if (locked_grant) begin
                        if (win_oth_req && lock_cnt != MAX_CNT) begin
                            lock_cnt <= lock_cnt + 8'd1;
                        end
                    end else begin
                        lock_cnt <= 8'd0;
                    end
                end else begin
                    locked   <= 1'b0;
                    lock_cnt <= 8'd0;
                end
            end
        end
    end

endmodule
